calc_ctrl: RTL and testbench
============================

# calc_ctrl

Key-entry sequencer for the one-digit BCD add/subtract calculator. It collects operand A, an operator and operand B from a keypad strobe. It then drives the shared combinational one-digit BCD adder (4-bit X/Y in, 4-bit S and CARRY out) for one pass (add) or two to three passes (subtract via nines' complement). Finally it holds the signed result for the display.

## Interface
Parameters:
- none; key codes are fixed: 0x0–0x9 digit, 0xA plus, 0xB minus, 0xC equals, 0xD clear, 0xE/0xF ignored.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- KEY_VALID  in  1  one-cycle key strobe.
- KEY  in  4  key code, qualified by KEY_VALID.
- ADD_X  out  4  operand X to BCD adder (registered).
- ADD_Y  out  4  operand Y to BCD adder (registered).
- ADD_S  in  4  BCD sum digit from adder (combinational from ADD_X/ADD_Y).
- ADD_CARRY  in  1  decimal carry from adder.
- DISP  out  4  displayed BCD digit.
- DISP_CARRY  out  1  tens digit (=1) of an addition result.
- DISP_NEG  out  1  result is negative (subtraction only).
- BUSY  out  1  high while adder passes are in progress.
- RES_VALID  out  1  one-cycle pulse when a result is loaded into DISP.

## Operation
- Registers: A[3:0], B[3:0], OP (0 add, 1 sub), T[3:0] pass result, C1 carry of pass 1.
- States: IDLE, GOT_A, GOT_OP, GOT_B, P1, P2, P3, DONE.
- IDLE: digit → A=digit, GOT_A. Other keys are ignored.
- GOT_A: digit → replace A. Plus/minus → OP, GOT_OP. Equals is ignored.
- GOT_OP: digit → B=digit, GOT_B. Plus/minus → replace OP.
- GOT_B: digit → replace B. Equals → P1. Plus/minus is ignored.
- Passes (loaded at the edge entering the state, S/CARRY captured at the edge leaving it):
  - P1: X=A, Y=B (add) or Y=9−B (sub).
  - Add: capture DISP=S, DISP_CARRY=CARRY, DISP_NEG=0; go to DONE.
  - Sub: T=S, C1=CARRY; go to P2 with X=T, Y=1.
- P2 capture (sub only):
  - If C1|CARRY: DISP=S, DISP_NEG=0; go to DONE.
  - Otherwise: T=S; go to P3 with X=9−T, Y=1.
- P3 capture: DISP=S, DISP_NEG=1; go to DONE. DISP_CARRY is always 0 for sub.
- DONE: result held.
  - Digit → A=digit, clear DISP_CARRY/DISP_NEG, go to GOT_A.
  - Other keys except clear are ignored.
- DISP: 0 in IDLE, A in GOT_A/GOT_OP, B in GOT_B, held through P1–P3, result in DONE.
- Clear (0xD), accepted in any state including P1–P3:
  - Go to IDLE; DISP, DISP_CARRY, DISP_NEG, ADD_X, ADD_Y = 0.
  - Any pending result is discarded with no RES_VALID.
- During P1–P3, all keys except clear are ignored.
- KEY 0xE/0xF is ignored everywhere.
- ADD_X/ADD_Y hold their last value outside pass loading.
- All digits stay within 0–9; 9−v is computed only on v ≤ 9.

## Timing
- Reset (RST_N low, async): state IDLE; all outputs 0 (ADD_X, ADD_Y, DISP, DISP_CARRY, DISP_NEG, BUSY, RES_VALID); A, B, OP, T, C1 = 0.
- Key accepted on the edge where KEY_VALID=1; the display update is visible after that edge.
- Equals accepted at edge N → P1 during cycle N..N+1.
  - Add: result and RES_VALID after edge N+2.
  - Sub non-negative: after edge N+3.
  - Sub negative: after edge N+4.
- BUSY is registered: high exactly while in P1–P3 and low again when RES_VALID rises.
- RES_VALID is high for exactly one cycle, in the first DONE cycle.
- Adder output is sampled one full cycle after its operands are registered; no combinational path from KEY to ADD_X/ADD_Y.
- RST_N asserted mid-pass: immediate return to reset values; no RES_VALID.
- KEY_VALID held high for several cycles counts as one key per cycle.

## Test plan
- Reset: RST_N low at arbitrary time → all outputs 0, state IDLE; a later 3,+,5,= still works.
- Add 3+5= → ADD_X=3/ADD_Y=5 in P1; DISP=8, DISP_CARRY=0, DISP_NEG=0; RES_VALID one cycle, 2 edges after equals.
- Add 9+9= → DISP=8, DISP_CARRY=1; 4+6= → DISP=0, DISP_CARRY=1.
- Subtract:
  - 7−3= → (7,6),(3,1); DISP=4, NEG=0, 3 edges.
  - 4−4= → (4,5),(9,1); DISP=0, NEG=0.
  - 1−8= → (1,1),(2,1),(6,1); DISP=7, NEG=1, 4 edges.
- Clear during P2 of 1−8 → IDLE, outputs 0, no RES_VALID; keys 5,+ during BUSY are ignored.
- Illegal sequences:
  - = in GOT_A is ignored.
  - 2,7 → A=7.
  - +,− → OP=sub.
  - 0xE ignored.
  - After DONE, digit 4 → DISP=4, flags cleared.

Source files
------------

// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
//
// Key-entry sequencer for a one-digit BCD add/subtract calculator. It collects
// operand A, an operator and operand B from a keypad strobe. It then runs the
// external combinational one-digit BCD adder for the passes the operation
// needs. Finally it holds the signed result for the display.
//
// Subtraction uses the nines' complement:
//   pass 1 : A + (9 - B)
//   pass 2 : end-around +1
//   pass 3 : re-complement, only when the result is negative
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   key_valid   in   one-cycle key strobe
//   key[3:0]    in   key code (0-9 digit, A plus, B minus, C equals, D clear)
//   add_x[3:0]  out  registered X operand to the BCD adder
//   add_y[3:0]  out  registered Y operand to the BCD adder
//   add_s[3:0]  in   BCD sum digit from the adder
//   add_carry   in   decimal carry from the adder
//   disp[3:0]   out  displayed BCD digit
//   disp_carry  out  tens digit of an addition result
//   disp_neg    out  result of a subtraction is negative
//   busy        out  adder passes in progress
//   res_valid   out  one-cycle pulse when a result is loaded into disp
// -----------------------------------------------------------------------------
module calc_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key,
   output logic [3:0] add_x,
   output logic [3:0] add_y,
   input  logic [3:0] add_s,
   input  logic       add_carry,
   output logic [3:0] disp,
   output logic       disp_carry,
   output logic       disp_neg,
   output logic       busy,
   output logic       res_valid
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GOT_A  = 3'd1,
      GOT_OP = 3'd2,
      GOT_B  = 3'd3,
      P1     = 3'd4,
      P2     = 3'd5,
      P3     = 3'd6,
      DONE   = 3'd7
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] a_reg, a_next;
   logic [3:0] b_reg, b_next;
   logic       op_reg, op_next;          // 0 add, 1 subtract
   logic [3:0] t_reg, t_next;            // result of the previous pass
   logic       c1_reg, c1_next;          // carry out of pass 1
   logic       p1_settle_reg, p1_settle_next;
   logic [3:0] add_x_reg, add_x_next;
   logic [3:0] add_y_reg, add_y_next;
   logic [3:0] disp_reg, disp_next;
   logic       disp_carry_reg, disp_carry_next;
   logic       disp_neg_reg, disp_neg_next;
   logic       busy_reg, busy_next;
   logic       res_valid_reg, res_valid_next;

   logic       key_digit;
   logic       key_op;
   logic       key_equals;
   logic       key_clear;

   // Key decode; 0xE/0xF fall into none of these classes and are ignored.
   assign key_digit  = key_valid && (key <= 4'd9);
   assign key_op     = key_valid && ((key == 4'hA) || (key == 4'hB));
   assign key_equals = key_valid && (key == 4'hC);
   assign key_clear  = key_valid && (key == 4'hD);

   function automatic logic [3:0] nines(input logic [3:0] v);
      return 4'd9 - v;
   endfunction

   always_comb begin
      state_next      = state_reg;
      a_next          = a_reg;
      b_next          = b_reg;
      op_next         = op_reg;
      t_next          = t_reg;
      c1_next         = c1_reg;
      p1_settle_next  = p1_settle_reg;
      add_x_next      = add_x_reg;
      add_y_next      = add_y_reg;
      disp_next       = disp_reg;
      disp_carry_next = disp_carry_reg;
      disp_neg_next   = disp_neg_reg;
      res_valid_next  = 1'b0;

      if (key_clear) begin
         // Clear wins in every state and silently drops any pending result.
         state_next      = IDLE;
         p1_settle_next  = 1'b0;
         add_x_next      = 4'd0;
         add_y_next      = 4'd0;
         disp_next       = 4'd0;
         disp_carry_next = 1'b0;
         disp_neg_next   = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (key_digit) begin
                  a_next     = key;
                  disp_next  = key;
                  state_next = GOT_A;
               end
            end
            GOT_A: begin
               if (key_digit) begin
                  a_next    = key;
                  disp_next = key;
               end else if (key_op) begin
                  op_next    = (key == 4'hB);
                  state_next = GOT_OP;
               end
            end
            GOT_OP: begin
               if (key_digit) begin
                  b_next     = key;
                  disp_next  = key;
                  state_next = GOT_B;
               end else if (key_op) begin
                  op_next = (key == 4'hB);
               end
            end
            GOT_B: begin
               if (key_digit) begin
                  b_next    = key;
                  disp_next = key;
               end else if (key_equals) begin
                  add_x_next     = a_reg;
                  add_y_next     = op_reg ? nines(b_reg) : b_reg;
                  p1_settle_next = 1'b1;
                  state_next     = P1;
               end
            end
            P1: begin
               // The first pass spends one extra cycle with fresh operands
               // before the adder output is captured.
               if (p1_settle_reg) begin
                  p1_settle_next = 1'b0;
               end else if (!op_reg) begin
                  disp_next       = add_s;
                  disp_carry_next = add_carry;
                  disp_neg_next   = 1'b0;
                  res_valid_next  = 1'b1;
                  state_next      = DONE;
               end else begin
                  t_next     = add_s;
                  c1_next    = add_carry;
                  add_x_next = add_s;
                  add_y_next = 4'd1;
                  state_next = P2;
               end
            end
            P2: begin
               if (c1_reg || add_carry) begin
                  disp_next       = add_s;
                  disp_carry_next = 1'b0;
                  disp_neg_next   = 1'b0;
                  res_valid_next  = 1'b1;
                  state_next      = DONE;
               end else begin
                  // No carry anywhere: the magnitude is the nines' complement
                  // of this pass plus one.
                  t_next     = add_s;
                  add_x_next = nines(add_s);
                  add_y_next = 4'd1;
                  state_next = P3;
               end
            end
            P3: begin
               disp_next       = add_s;
               disp_carry_next = 1'b0;
               disp_neg_next   = 1'b1;
               res_valid_next  = 1'b1;
               state_next      = DONE;
            end
            DONE: begin
               if (key_digit) begin
                  a_next          = key;
                  disp_next       = key;
                  disp_carry_next = 1'b0;
                  disp_neg_next   = 1'b0;
                  state_next      = GOT_A;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end

      busy_next = (state_next == P1) || (state_next == P2) || (state_next == P3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         a_reg          <= 4'd0;
         b_reg          <= 4'd0;
         op_reg         <= 1'b0;
         t_reg          <= 4'd0;
         c1_reg         <= 1'b0;
         p1_settle_reg  <= 1'b0;
         add_x_reg      <= 4'd0;
         add_y_reg      <= 4'd0;
         disp_reg       <= 4'd0;
         disp_carry_reg <= 1'b0;
         disp_neg_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         res_valid_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         a_reg          <= a_next;
         b_reg          <= b_next;
         op_reg         <= op_next;
         t_reg          <= t_next;
         c1_reg         <= c1_next;
         p1_settle_reg  <= p1_settle_next;
         add_x_reg      <= add_x_next;
         add_y_reg      <= add_y_next;
         disp_reg       <= disp_next;
         disp_carry_reg <= disp_carry_next;
         disp_neg_reg   <= disp_neg_next;
         busy_reg       <= busy_next;
         res_valid_reg  <= res_valid_next;
      end
   end

   assign add_x      = add_x_reg;
   assign add_y      = add_y_reg;
   assign disp       = disp_reg;
   assign disp_carry = disp_carry_reg;
   assign disp_neg   = disp_neg_reg;
   assign busy       = busy_reg;
   assign res_valid  = res_valid_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_ctrl
//
// Bench for calc_ctrl with a behavioural one-digit BCD adder attached.
// Table vectors cover whole expressions including per-pass adder operands;
// hand-written sequences cover clear/reset mid-pass and ignored keys; a random
// key stream is checked every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_calc_ctrl;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key;
   logic [3:0] add_x;
   logic [3:0] add_y;
   logic [3:0] add_s;
   logic       add_carry;
   logic [3:0] disp;
   logic       disp_carry;
   logic       disp_neg;
   logic       busy;
   logic       res_valid;

   int n_checks = 0;
   int n_errors = 0;

   calc_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key        (key),
      .add_x      (add_x),
      .add_y      (add_y),
      .add_s      (add_s),
      .add_carry  (add_carry),
      .disp       (disp),
      .disp_carry (disp_carry),
      .disp_neg   (disp_neg),
      .busy       (busy),
      .res_valid  (res_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural one-digit BCD adder.
   int sum_i;
   always_comb begin
      sum_i = int'(add_x) + int'(add_y);
      if (sum_i > 9) begin
         add_s     = 4'(sum_i - 10);
         add_carry = 1'b1;
      end else begin
         add_s     = 4'(sum_i);
         add_carry = 1'b0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive inputs after the falling edge, sample 1 ns after rise.
   task automatic step(input logic v, input logic [3:0] k);
      @(negedge clk);
      key_valid = v;
      key       = k;
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level reference model ----------------
   // phase: 0 idle, 1 have A, 2 have op, 3 have B, 4 computing, 5 result shown
   int m_phase, m_a, m_b, m_sub, m_cnt;
   int m_disp, m_carry, m_neg, m_busy, m_rv;
   int p_disp, p_carry, p_neg;

   task automatic model_step(input logic v, input logic [3:0] k);
      int ki;
      int r;
      ki   = int'(k);
      m_rv = 0;
      if (v && ki == 13) begin
         m_phase = 0; m_disp = 0; m_carry = 0; m_neg = 0; m_busy = 0; m_cnt = 0;
         return;
      end
      if (m_phase == 4) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_disp = p_disp; m_carry = p_carry; m_neg = p_neg;
            m_rv = 1; m_busy = 0; m_phase = 5;
         end
         return;
      end
      if (!v || ki >= 14) return;
      case (m_phase)
         0: if (ki <= 9) begin m_a = ki; m_disp = ki; m_phase = 1; end
         1: begin
            if (ki <= 9) begin m_a = ki; m_disp = ki; end
            else if (ki == 10 || ki == 11) begin m_sub = (ki == 11); m_phase = 2; end
         end
         2: begin
            if (ki <= 9) begin m_b = ki; m_disp = ki; m_phase = 3; end
            else if (ki == 10 || ki == 11) m_sub = (ki == 11);
         end
         3: begin
            if (ki <= 9) begin m_b = ki; m_disp = ki; end
            else if (ki == 12) begin
               if (!m_sub) begin
                  r = m_a + m_b;
                  p_disp = r % 10; p_carry = r / 10; p_neg = 0; m_cnt = 2;
               end else begin
                  r = m_a - m_b;
                  p_carry = 0;
                  p_neg   = (r < 0);
                  p_disp  = (r < 0) ? -r : r;
                  m_cnt   = (r < 0) ? 4 : 3;
               end
               m_busy = 1; m_phase = 4;
            end
         end
         5: if (ki <= 9) begin
            m_a = ki; m_disp = ki; m_carry = 0; m_neg = 0; m_phase = 1;
         end
         default: ;
      endcase
   endtask

   typedef struct {
      int a; int sub; int b;
      int x1; int y1; int x2; int y2; int x3; int y3;
      int disp; int carry; int neg; int lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [3:0] k;
      int r;
      vecs[0] = '{3, 0, 5, 3, 5, 0, 0, 0, 0, 8, 0, 0, 2};
      vecs[1] = '{9, 0, 9, 9, 9, 0, 0, 0, 0, 8, 1, 0, 2};
      vecs[2] = '{4, 0, 6, 4, 6, 0, 0, 0, 0, 0, 1, 0, 2};
      vecs[3] = '{7, 1, 3, 7, 6, 3, 1, 0, 0, 4, 0, 0, 3};
      vecs[4] = '{4, 1, 4, 4, 5, 9, 1, 0, 0, 0, 0, 0, 3};
      vecs[5] = '{1, 1, 8, 1, 1, 2, 1, 6, 1, 7, 0, 1, 4};
      vecs[6] = '{0, 1, 9, 0, 0, 0, 1, 8, 1, 9, 0, 1, 4};
      vecs[7] = '{9, 1, 0, 9, 9, 8, 1, 0, 0, 9, 0, 0, 3};

      rst_n = 1'b0; key_valid = 1'b0; key = 4'd0;

      // ---- reset state ----
      @(negedge clk); @(negedge clk);
      chk("rst_add_x", add_x, 0);   chk("rst_add_y", add_y, 0);
      chk("rst_disp", disp, 0);     chk("rst_disp_carry", disp_carry, 0);
      chk("rst_disp_neg", disp_neg, 0);
      chk("rst_busy", busy, 0);     chk("rst_res_valid", res_valid, 0);
      rst_n = 1'b1;
      $display("reset: outputs checked");

      // ---- table-driven expressions ----
      for (int i = 0; i < 8; i++) begin
         step(1, 4'hD);
         step(1, 4'(vecs[i].a));
         chk("entry_disp_a", disp, vecs[i].a);
         step(1, vecs[i].sub != 0 ? 4'hB : 4'hA);
         step(1, 4'(vecs[i].b));
         chk("entry_disp_b", disp, vecs[i].b);
         step(1, 4'hC);
         for (int j = 0; j <= vecs[i].lat; j++) begin
            if (j > 0) step(0, 4'h0);
            if (j <= 1) begin
               chk("pass1_x", add_x, vecs[i].x1);
               chk("pass1_y", add_y, vecs[i].y1);
            end
            if (j == 2 && vecs[i].lat >= 3) begin
               chk("pass2_x", add_x, vecs[i].x2);
               chk("pass2_y", add_y, vecs[i].y2);
            end
            if (j == 3 && vecs[i].lat == 4) begin
               chk("pass3_x", add_x, vecs[i].x3);
               chk("pass3_y", add_y, vecs[i].y3);
            end
            if (j < vecs[i].lat) begin
               chk("pass_busy", busy, 1);
               chk("pass_res_valid", res_valid, 0);
               chk("pass_disp_held", disp, vecs[i].b);
            end else begin
               chk("res_disp", disp, vecs[i].disp);
               chk("res_disp_carry", disp_carry, vecs[i].carry);
               chk("res_disp_neg", disp_neg, vecs[i].neg);
               chk("res_valid_pulse", res_valid, 1);
               chk("res_busy_low", busy, 0);
            end
         end
         step(0, 4'h0);
         chk("res_valid_one_cycle", res_valid, 0);
         chk("res_disp_hold", disp, vecs[i].disp);
         $display("vector %0d: %0d %s %0d = %s%0d%0d (latency %0d)", i, vecs[i].a,
                  vecs[i].sub != 0 ? "-" : "+", vecs[i].b, vecs[i].neg != 0 ? "-" : "",
                  vecs[i].carry, vecs[i].disp, vecs[i].lat);
      end

      // ---- clear during pass 2 of 1-8; keys 5,+ while busy ignored ----
      step(1, 4'hD); step(1, 4'h1); step(1, 4'hB); step(1, 4'h8); step(1, 4'hC);
      step(1, 4'h5);
      chk("busy_key5_ignored", disp, 8);
      step(1, 4'hA);
      chk("busy_plus_ignored", disp, 8);
      chk("busy_still_high", busy, 1);
      step(1, 4'hD);
      chk("clr_disp", disp, 0);     chk("clr_carry", disp_carry, 0);
      chk("clr_neg", disp_neg, 0);  chk("clr_busy", busy, 0);
      chk("clr_add_x", add_x, 0);   chk("clr_add_y", add_y, 0);
      chk("clr_rv", res_valid, 0);
      for (int j = 0; j < 4; j++) begin
         step(0, 4'h0);
         chk("clr_no_result", res_valid, 0);
         chk("clr_disp_zero", disp, 0);
      end
      $display("sequence: clear during pass 2 of 1-8");

      // ---- ignored / replaced keys ----
      step(1, 4'h2);
      step(1, 4'hC);
      chk("eq_in_got_a_disp", disp, 2);
      chk("eq_in_got_a_busy", busy, 0);
      step(0, 4'h0);
      chk("eq_in_got_a_busy2", busy, 0);
      step(1, 4'h7);
      chk("replace_a", disp, 7);
      step(1, 4'hA); step(1, 4'hB); step(1, 4'hE);
      chk("key_e_ignored", disp, 7);
      step(1, 4'h3);
      step(1, 4'hA);
      chk("op_in_got_b_ignored", disp, 3);
      step(1, 4'hF);
      step(1, 4'hC);
      step(0, 4'h0); step(0, 4'h0); step(0, 4'h0);
      chk("seq_7m3_disp", disp, 4);
      chk("seq_7m3_neg", disp_neg, 0);
      chk("seq_7m3_rv", res_valid, 1);
      $display("sequence: 2 = 7 + - E 3 + F = gives 4");

      // ---- digit after a result clears the flags ----
      step(1, 4'h9); step(1, 4'hA); step(1, 4'h9); step(1, 4'hC);
      step(0, 4'h0); step(0, 4'h0);
      chk("seq_9p9_carry", disp_carry, 1);
      step(1, 4'h4);
      chk("after_done_disp", disp, 4);
      chk("after_done_carry", disp_carry, 0);
      step(1, 4'hB); step(1, 4'h8); step(1, 4'hC);
      for (int j = 0; j < 4; j++) step(0, 4'h0);
      chk("seq_4m8_disp", disp, 4);
      chk("seq_4m8_neg", disp_neg, 1);
      step(1, 4'h6);
      chk("after_neg_disp", disp, 6);
      chk("after_neg_neg", disp_neg, 0);
      $display("sequence: digit after result clears flags");

      // ---- async reset in the middle of a pass ----
      step(1, 4'hD); step(1, 4'h3); step(1, 4'hA); step(1, 4'h5); step(1, 4'hC);
      step(0, 4'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);   chk("arst_disp", disp, 0);
      chk("arst_add_x", add_x, 0); chk("arst_add_y", add_y, 0);
      chk("arst_rv", res_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 4'h0); step(0, 4'h0);
      chk("arst_no_result", res_valid, 0);
      step(1, 4'h3); step(1, 4'hA); step(1, 4'h5); step(1, 4'hC);
      step(0, 4'h0); step(0, 4'h0);
      chk("arst_then_disp", disp, 8);
      chk("arst_then_rv", res_valid, 1);
      $display("sequence: reset mid-pass then 3+5=8");

      // ---- random key stream vs model ----
      step(1, 4'hD);
      m_phase = 0; m_a = 0; m_b = 0; m_sub = 0; m_cnt = 0;
      m_disp = 0; m_carry = 0; m_neg = 0; m_busy = 0; m_rv = 0;
      for (int c = 0; c < 3000; c++) begin
         logic v;
         r = int'($urandom_range(0, 99));
         if (r < 4)       k = 4'hD;
         else if (r < 16) k = 4'hC;
         else if (r < 30) k = ($urandom_range(0, 1) != 0) ? 4'hA : 4'hB;
         else if (r < 34) k = ($urandom_range(0, 1) != 0) ? 4'hE : 4'hF;
         else             k = 4'($urandom_range(0, 9));
         v = ($urandom_range(0, 3) != 0);
         step(v, k);
         model_step(v, k);
         chk("rand_disp", disp, m_disp);
         chk("rand_carry", disp_carry, m_carry);
         chk("rand_neg", disp_neg, m_neg);
         chk("rand_busy", busy, m_busy);
         chk("rand_rv", res_valid, m_rv);
         if (m_rv != 0)
            $display("random: %0d %s %0d -> %s%0d%0d", m_a, m_sub != 0 ? "-" : "+",
                     m_b, m_neg != 0 ? "-" : "", m_carry, m_disp);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
